// File: rtl/lifo_frame_reverser.sv
// rtl/lifo_frame_reverser.sv - byte frame reverser driving a registered-read LIFO stack
module lifo_frame_reverser #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_error,
  output logic              ovf_err,
  output logic              stk_err_seen,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_DISCARD = 3'd1,
    ST_POP     = 3'd2,
    ST_LOAD    = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_valid;
  logic                r_m_last;
  logic                r_ovf_err;
  logic                r_disc_first;
  logic                r_err_seen;
  logic                w_full;
  logic                w_empty;
  logic                w_ready;
  logic                w_push;
  logic                w_pop;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // Next-state and stack strobes; all strobes are masked while reset is held
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ready = !w_full;
        if (s_valid && !w_full) begin
          w_push = 1'b1;
          if (s_last) begin
            w_next = ST_POP;
          end
        end else if (s_valid && w_full) begin
          // Stack is full and the frame has not ended: drop the rest of it
          w_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        w_ready = 1'b1;
        if (s_valid && s_last) begin
          w_next = ST_POP;
        end
      end
      ST_POP: begin
        w_pop  = !w_empty;
        w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_next = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          w_next = r_m_last ? ST_FILL : ST_POP;
        end
      end
      default: begin
        w_next = ST_FILL;
      end
    endcase
  end

  assign s_ready      = rst_n & w_ready;
  assign stk_push     = rst_n & w_push;
  assign stk_pop      = rst_n & w_pop;
  assign stk_wdata    = stk_push ? s_data : '0;
  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;
  assign m_last       = r_m_last;
  assign ovf_err      = r_ovf_err;
  assign stk_err_seen = r_err_seen;
  assign busy         = (r_state != ST_FILL);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Stack occupancy; push and pop are mutually exclusive by state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (stk_push) begin
      r_count <= r_count + LP_ONE;
    end else if (stk_pop) begin
      r_count <= r_count - LP_ONE;
    end
  end

  // Output beat register: loaded from the stack read data the cycle after a pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_m_data  <= stk_rdata;
      r_m_valid <= 1'b1;
      r_m_last  <= w_empty;
    end else if (r_state == ST_OUT && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Overflow pulse on the first dropped beat of each oversize frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_err    <= 1'b0;
      r_disc_first <= 1'b1;
    end else begin
      r_ovf_err <= (r_state == ST_DISCARD) && s_valid && r_disc_first;
      if (r_state != ST_DISCARD) begin
        r_disc_first <= 1'b1;
      end else if (s_valid) begin
        r_disc_first <= 1'b0;
      end
    end
  end

  // Sticky record of any stack error, which only an integration fault can cause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_seen <= 1'b0;
    end else if (stk_error) begin
      r_err_seen <= 1'b1;
    end
  end

endmodule

// File: doc/lifo_frame_reverser.md
# lifo_frame_reverser

Stream-side controller that drives the team's 16-deep byte `lifo` stack.
- Accepts a byte frame on a valid/ready input stream and pushes every beat into the stack.
- After the last beat it pops the stack dry and emits the bytes on a valid/ready output stream in reverse order.
- It is the initiator for the stack's push/pop port and sits between a byte source and a byte sink.

## Interface
- `DATA_W`, 8: byte width; must equal the stack data width.
- `DEPTH`, 16: stack depth; must equal the stack depth.
- `CNT_W`, 5: occupancy counter width, holds 0..DEPTH.

Ports:
- `clk` in 1: single clock; all logic rises on it.
- `rst_n` in 1: synchronous, active-low reset.
- `s_data` in DATA_W: input byte.
- `s_valid` in 1: input beat valid.
- `s_last` in 1: input beat is the frame end.
- `s_ready` out 1: block accepts the input beat.
- `m_data` out DATA_W: output byte, registered.
- `m_valid` out 1: output beat valid, registered.
- `m_last` out 1: output beat is the frame end, registered.
- `m_ready` in 1: sink accepts the output beat.
- `stk_push` out 1: stack push strobe.
- `stk_pop` out 1: stack pop strobe.
- `stk_wdata` out DATA_W: byte to the stack.
- `stk_rdata` in DATA_W: stack registered read data.
- `stk_error` in 1: stack error flag.
- `ovf_err` out 1: one-cycle pulse on the first discarded beat of an oversize frame.
- `stk_err_seen` out 1: sticky until reset; set when `stk_error` is sampled high.
- `busy` out 1: high in any state other than FILL.

## Operation
States: FILL, DISCARD, POP, LOAD, OUT. Internal `count` (CNT_W) tracks stack occupancy.

- **FILL**
  - `s_ready` = (count < DEPTH).
  - On handshake: `stk_push`=1 and `stk_wdata`=`s_data`, both combinational; count+1.
  - Handshake with `s_last` goes to POP.
  - count==DEPTH with `s_valid` and no `s_last` pending goes to DISCARD.
- **DISCARD**
  - `s_ready`=1; no push.
  - `ovf_err` pulses on the first discarded beat only.
  - Handshake with `s_last` goes to POP.
- **POP**
  - `stk_pop`=1 for exactly one cycle; count-1; goes to LOAD.
- **LOAD**
  - `m_data` <= `stk_rdata`, `m_valid` <= 1, `m_last` <= (count==0); goes to OUT.
- **OUT**
  - Holds `m_data`, `m_valid` and `m_last` stable until `m_ready`.
  - On handshake, `m_valid` <= 0.
  - Goes to FILL if `m_last` was set, otherwise to POP.

Rules:
- `stk_push` and `stk_pop` are never high in the same cycle.
- Push is never issued at count==DEPTH; pop is never issued at count==0. `stk_error` therefore indicates an integration fault and only sets `stk_err_seen`.
- `s_ready` is low in POP, LOAD and OUT (half-duplex).
- Counting uses CNT_W-bit arithmetic with no wrap; count stays within 0..DEPTH.
- A frame is at least 1 byte: the first beat may carry `s_last`.
- Oversize frame: the first DEPTH bytes are kept and returned reversed; later beats are dropped.

## Timing
- **Reset (`rst_n`=0 at a rising edge):**
  - State = FILL, count = 0.
  - `m_data`=0, `m_valid`=0, `m_last`=0, `ovf_err`=0, `stk_err_seen`=0, `busy`=0.
  - `stk_push`=0, `stk_pop`=0, `stk_wdata`=0.
  - `s_ready` is 0 while `rst_n`=0 and 1 from the first cycle after release.
- **Reset mid-frame or mid-drain:** abandons the frame at once with no further strobes. The stack must be reset by the same event; at top level, stack `rst` = ~`rst_n`.
- **Drain latency:** last input handshake in cycle t → POP in t+1 → LOAD in t+2 → `m_valid` high in t+3.
- **Throughput:** with `m_ready` held high, one output byte every 3 cycles.
- **Turnaround:** after the final output handshake in cycle u, `s_ready`=1 in u+1.
- **`stk_rdata`:** sampled only in LOAD, the cycle after the pop strobe, matching the stack's registered read.
- **`ovf_err`:** asserted in the cycle after the first discarded handshake, for one cycle.

## Test plan
- Frame 0x11,0x22,0x33 (last on 0x33) → output 0x33,0x22,0x11; `m_last` only on 0x11; first `m_valid` 3 cycles after the last handshake.
- Single beat 0xA5 with `s_last` → one output 0xA5 with `m_last`=1; then `s_ready`=1 the next cycle.
- 16-beat frame 0x00..0x0F → `s_ready` high through beat 16, output 0x0F..0x00, `ovf_err` never set.
- 20-beat frame 0x00..0x13 → 4 beats discarded, `ovf_err` pulses once, output 0x0F..0x00, `stk_error` stays 0.
- Frame 0x01,0x02 with `m_ready` low for 5 cycles in OUT → `m_data`=0x02 stable and `m_valid` held; no extra `stk_pop`; then 0x01 with `m_last`.
- `rst_n` low for 1 cycle during the drain of a 4-byte frame → all outputs at reset values; the next frame 0xAA,0xBB returns 0xBB,0xAA.
